// File: rtl/r4_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : r4_ctrl_pkg                                                      |
// | Shared types and constants for the radix-4 butterfly sequencer:            |
// |   c_WIDTH   - default sample component width                              |
// |   state_t   - sequencer state {LOAD, RUN}                                  |
// |   c_BF_CODE - butterfly control code {c1,c2,c3} for output index k        |
// |   sample_t  - one complex sample, packed {im, re}                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package r4_ctrl_pkg;

    localparam int c_WIDTH = 4;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Control code steering the butterfly to produce output k.
    localparam logic [2:0] c_BF_CODE [0:3] = '{3'b000, 3'b110, 3'b010, 3'b111};

    // Field order puts im above re, matching the slot layout on bf_x.
    typedef struct packed {
        logic [c_WIDTH-1:0] im;
        logic [c_WIDTH-1:0] re;
    } sample_t;

endpackage : r4_ctrl_pkg
`default_nettype wire

// File: rtl/r4_sample_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : r4_sample_bank                                                   |
// | Four-entry complex sample register bank with write pointer and full flag. |
// | Ports:                                                                     |
// |   clk, rst   clock, synchronous active-high reset (clears data and flags) |
// |   i_wr_en    write request; ignored while the bank is full                |
// |   i_clr      releases a full bank so it can be reloaded                   |
// |   i_re/i_im  sample to write at the current pointer                       |
// |   o_full     all four slots hold a frame                                  |
// |   o_wr_last  slot 3 is being written this cycle (bank full next cycle)    |
// |   o_data     {im3,re3,im2,re2,im1,re1,im0,re0}                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module r4_sample_bank
    import r4_ctrl_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_wr_en,
    input  logic               i_clr,
    input  logic [WIDTH-1:0]   i_re,
    input  logic [WIDTH-1:0]   i_im,
    output logic               o_full,
    output logic               o_wr_last,
    output logic [8*WIDTH-1:0] o_data
);

    logic [8*WIDTH-1:0] r_data_q, w_data_d;
    logic [1:0]         r_wr_ptr_q, w_wr_ptr_d;
    logic               r_full_q, w_full_d;
    logic               w_wr;

    always_comb begin
        w_wr       = i_wr_en && !r_full_q;
        w_data_d   = r_data_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_full_d   = r_full_q;
        for (int n = 0; n < 4; n++) begin
            if (w_wr && (r_wr_ptr_q == 2'(n))) begin
                w_data_d[n*2*WIDTH +: 2*WIDTH] = {i_im, i_re};
            end
        end
        if (w_wr) begin
            // Pointer wraps 3 -> 0 on its own, ready for the next frame.
            w_wr_ptr_d = r_wr_ptr_q + 2'd1;
            if (r_wr_ptr_q == 2'd3) begin
                w_full_d = 1'b1;
            end
        end
        if (i_clr) begin
            w_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q   <= '0;
            r_wr_ptr_q <= 2'd0;
            r_full_q   <= 1'b0;
        end else begin
            r_data_q   <= w_data_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_full_q   <= w_full_d;
        end
    end

    assign o_full    = r_full_q;
    assign o_wr_last = w_wr && (r_wr_ptr_q == 2'd3);
    assign o_data    = r_data_q;

endmodule : r4_sample_bank
`default_nettype wire

// File: rtl/r4_butter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : r4_butter_ctrl                                                   |
// | Sequencer for a time-shared combinational radix-4 butterfly. Collects a   |
// | frame of 4 complex samples, holds it on bf_x, steps bf_c through the four |
// | output codes and streams each captured result out with its index k.       |
// | Ports:                                                                     |
// |   clk, rst             clock, synchronous active-high reset              |
// |   in_valid/in_ready    sample stream handshake, in_re/in_im payload      |
// |   bf_x, bf_c           held frame and control code to the butterfly      |
// |   bf_xro, bf_xio       butterfly result (combinational from bf_x/bf_c)   |
// |   out_valid/out_ready  result stream handshake                           |
// |   out_re/out_im/out_idx captured result and its index k                  |
// | Build option: define R4_CTRL_DBLBUF_EN for two sample banks so the next   |
// | frame loads while the current one runs.                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module r4_butter_ctrl
    import r4_ctrl_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_re,
    input  logic [WIDTH-1:0]   in_im,
    output logic [8*WIDTH-1:0] bf_x,
    output logic [2:0]         bf_c,
    input  logic [WIDTH-1:0]   bf_xro,
    input  logic [WIDTH-1:0]   bf_xio,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_re,
    output logic [WIDTH-1:0]   out_im,
    output logic [1:0]         out_idx
);

    state_t             r_state_q, w_state_d;
    logic [1:0]         r_k_q, w_k_d;
    logic               r_out_valid_q, w_out_valid_d;
    logic [WIDTH-1:0]   r_out_re_q, w_out_re_d;
    logic [WIDTH-1:0]   r_out_im_q, w_out_im_d;
    logic [1:0]         r_out_idx_q, w_out_idx_d;

    logic               w_accept;
    logic               w_cap;
    logic               w_clr_run;
    logic               w_load_full;
    logic [8*WIDTH-1:0] w_run_data;

`ifdef R4_CTRL_DBLBUF_EN
    // r_sel_q names the bank presented to the butterfly; the other one loads.
    logic               r_sel_q, w_sel_d;
    logic               w_swap;
    logic               w_load_last;
    logic [1:0]         w_full, w_last;
    logic [8*WIDTH-1:0] w_data [0:1];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic w_is_run;
        assign w_is_run = (r_sel_q == 1'(b));
        r4_sample_bank #(.WIDTH(WIDTH)) u_bank (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_accept && !w_is_run),
            .i_clr     (w_clr_run && w_is_run),
            .i_re      (in_re),
            .i_im      (in_im),
            .o_full    (w_full[b]),
            .o_wr_last (w_last[b]),
            .o_data    (w_data[b])
        );
    end

    assign w_load_full = w_full[~r_sel_q];
    assign w_load_last = w_last[~r_sel_q];
    assign w_run_data  = w_data[r_sel_q];
    assign w_sel_d     = w_swap ? ~r_sel_q : r_sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_q <= 1'b0;
        end else begin
            r_sel_q <= w_sel_d;
        end
    end
`else
    // Single bank: it loads in LOAD and is held (full) for the whole of RUN.
    logic w_unused_last;

    r4_sample_bank #(.WIDTH(WIDTH)) u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_accept),
        .i_clr     (w_clr_run),
        .i_re      (in_re),
        .i_im      (in_im),
        .o_full    (w_load_full),
        .o_wr_last (w_unused_last),
        .o_data    (w_run_data)
    );
`endif

    assign in_ready = !w_load_full;
    assign w_accept = in_valid && in_ready;
    // Capture whenever the output register is empty or drains this cycle.
    assign w_cap    = (r_state_q == RUN) && (!r_out_valid_q || out_ready);

    always_comb begin
        w_state_d     = r_state_q;
        w_k_d         = r_k_q;
        w_out_valid_d = r_out_valid_q;
        w_out_re_d    = r_out_re_q;
        w_out_im_d    = r_out_im_q;
        w_out_idx_d   = r_out_idx_q;
        w_clr_run     = 1'b0;
`ifdef R4_CTRL_DBLBUF_EN
        w_swap        = 1'b0;
`endif
        if (w_cap) begin
            w_out_valid_d = 1'b1;
            w_out_re_d    = bf_xro;
            w_out_im_d    = bf_xio;
            w_out_idx_d   = r_k_q;
            w_k_d         = r_k_q + 2'd1;
            if (r_k_q == 2'd3) begin
                w_clr_run = 1'b1;
`ifdef R4_CTRL_DBLBUF_EN
                // A frame completing on this very edge also counts, so a
                // steady stream swaps without a bubble.
                if (w_load_full || w_load_last) begin
                    w_swap = 1'b1;
                end else begin
                    w_state_d = LOAD;
                end
`else
                w_state_d = LOAD;
`endif
            end
        end else if (out_ready) begin
            w_out_valid_d = 1'b0;
        end

        // The registered full flag starts RUN one cycle after the 4th accept.
        if ((r_state_q == LOAD) && w_load_full) begin
            w_state_d = RUN;
            w_k_d     = 2'd0;
`ifdef R4_CTRL_DBLBUF_EN
            w_swap    = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= LOAD;
            r_k_q         <= 2'd0;
            r_out_valid_q <= 1'b0;
            r_out_re_q    <= '0;
            r_out_im_q    <= '0;
            r_out_idx_q   <= 2'd0;
        end else begin
            r_state_q     <= w_state_d;
            r_k_q         <= w_k_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_re_q    <= w_out_re_d;
            r_out_im_q    <= w_out_im_d;
            r_out_idx_q   <= w_out_idx_d;
        end
    end

    // Outside RUN the butterfly sees zeros and the k=0 code.
    assign bf_x      = (r_state_q == RUN) ? w_run_data : '0;
    assign bf_c      = (r_state_q == RUN) ? c_BF_CODE[r_k_q] : 3'b000;
    assign out_valid = r_out_valid_q;
    assign out_re    = r_out_re_q;
    assign out_im    = r_out_im_q;
    assign out_idx   = r_out_idx_q;

endmodule : r4_butter_ctrl
`default_nettype wire

// File: tb/tb_r4_butter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_r4_butter_ctrl                                                |
// | Bench for r4_butter_ctrl: a behavioural radix-4 butterfly closes the bf_* |
// | loop; directed frames with hand-computed results, stall, mid-frame reset, |
// | back-to-back and random-handshake scoreboard sequences.                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_r4_butter_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_re;
    logic [3:0]  in_im;
    logic [31:0] bf_x;
    logic [2:0]  bf_c;
    logic [3:0]  bf_xro;
    logic [3:0]  bf_xio;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_re;
    logic [3:0]  out_im;
    logic [1:0]  out_idx;

    int n_err;
    int n_chk;

    r4_butter_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .bf_x      (bf_x),
        .bf_c      (bf_c),
        .bf_xro    (bf_xro),
        .bf_xio    (bf_xio),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-point DFT, W = -j, modulo 16. Returns {im, re}.
    function automatic logic [7:0] dft4(input logic [31:0] x, input int k);
        int xr [4];
        int xi [4];
        int yr;
        int yi;
        for (int n = 0; n < 4; n++) begin
            xr[n] = int'(x[8*n +: 4]);
            xi[n] = int'(x[8*n+4 +: 4]);
        end
        case (k)
            0: begin yr = xr[0] + xr[1] + xr[2] + xr[3]; yi = xi[0] + xi[1] + xi[2] + xi[3]; end
            1: begin yr = xr[0] + xi[1] - xr[2] - xi[3]; yi = xi[0] - xr[1] - xi[2] + xr[3]; end
            2: begin yr = xr[0] - xr[1] + xr[2] - xr[3]; yi = xi[0] - xi[1] + xi[2] - xi[3]; end
            default: begin yr = xr[0] - xi[1] - xr[2] + xi[3]; yi = xi[0] + xr[1] - xi[2] - xr[3]; end
        endcase
        return {yi[3:0], yr[3:0]};
    endfunction

    function automatic logic [31:0] pack(input logic [15:0] re, input logic [15:0] im);
        logic [31:0] p;
        for (int n = 0; n < 4; n++) begin
            p[8*n +: 4]   = re[4*n +: 4];
            p[8*n+4 +: 4] = im[4*n +: 4];
        end
        return p;
    endfunction

    // Butterfly: decodes bf_c; an unknown code yields a recognisable junk value.
    always_comb begin
        case (bf_c)
            3'b000:  {bf_xio, bf_xro} = dft4(bf_x, 0);
            3'b110:  {bf_xio, bf_xro} = dft4(bf_x, 1);
            3'b010:  {bf_xio, bf_xro} = dft4(bf_x, 2);
            3'b111:  {bf_xio, bf_xro} = dft4(bf_x, 3);
            default: {bf_xio, bf_xro} = 8'h5A;
        endcase
    end

    logic [2:0] code_tb [4];

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [15:0] ere;
        logic [15:0] eim;
    } vec_t;

    vec_t tv [6];
    vec_t vg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_samples(input logic [15:0] re, input logic [15:0] im, input int n);
        for (int s = 0; s < n; s++) begin
            int g;
            g        = 0;
            in_valid = 1'b1;
            in_re    = re[4*s +: 4];
            in_im    = im[4*s +: 4];
            while (!in_ready && g < 20) begin
                @(negedge clk);
                g++;
            end
            chk("send_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int g;
        g = 0;
        while (!out_valid && g < 10) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic collect_frame(input vec_t v, input string tag);
        wait_valid(tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_idx%0d", tag, k), 32'(out_idx), 32'(k));
            chk($sformatf("%s_re%0d", tag, k), 32'(out_re), 32'(v.ere[4*k +: 4]));
            chk($sformatf("%s_im%0d", tag, k), 32'(out_im), 32'(v.eim[4*k +: 4]));
            chk($sformatf("%s_bfc%0d", tag, k), 32'(bf_c), 32'(code_tb[(k+1)%4]));
            @(negedge clk);
        end
        chk({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    // back-to-back and random test state (one set per process)
    logic [15:0] bb_re [3];
    logic [15:0] bb_im [3];
    logic [15:0] bb_ere [3];
    logic [15:0] bb_eim [3];
    int          fd_i, fd_g;
    logic        fd_acc;
    int          co_n, co_g, co_gaps, co_j, co_k;
    logic        co_seen;
    logic [9:0]  exp_q [$];
    logic [9:0]  exp_v;
    logic [15:0] rf_re, rf_im;
    int          rf_g;
    logic        rf_acc;
    int          rc_n, rc_g;

    initial begin
        n_err    = 0;
        n_chk    = 0;
        in_re    = '0;
        in_im    = '0;
        code_tb  = '{3'b000, 3'b110, 3'b010, 3'b111};
        tv[0] = '{16'h4321, 16'h0000, 16'hEEEA, 16'hE020};
        tv[1] = '{16'h0001, 16'h0000, 16'h1111, 16'h0000};
        tv[2] = '{16'h0010, 16'h0000, 16'h0F01, 16'h10F0};
        tv[3] = '{16'h0000, 16'h0010, 16'hF010, 16'h0F01};
        tv[4] = '{16'h9753, 16'h8642, 16'h0C88, 16'h8C04};
        tv[5] = '{16'hFFFF, 16'hFFFF, 16'h000C, 16'h000C};
        vg    = '{16'h8765, 16'h0000, 16'hEEEA, 16'hE020};

        // 1. reset state
        do_reset(2);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bf_c",      32'(bf_c),      32'd0);
        chk("rst_bf_x",      bf_x,           32'd0);
        chk("rst_out_re",    32'(out_re),    32'd0);
        chk("rst_out_im",    32'(out_im),    32'd0);
        chk("rst_out_idx",   32'(out_idx),   32'd0);

        // 2. first frame latency: valid two edges after the 4th accept
        send_samples(tv[0].re, tv[0].im, 4);
        chk("lat_t0_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_t1_valid", 32'(out_valid), 32'd0);
        chk("lat_bf_x",     bf_x, pack(tv[0].re, tv[0].im));
        chk("lat_bf_c",     32'(bf_c), 32'd0);
        chk("lat_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("lat_t2_valid", 32'(out_valid), 32'd1);
        collect_frame(tv[0], "lat");

        // table of directed frames
        for (int i = 0; i < 6; i++) begin
            send_samples(tv[i].re, tv[i].im, 4);
            collect_frame(tv[i], $sformatf("tv%0d", i));
        end

        // 3. backpressure: hold idx1 for 3 cycles
        send_samples(tv[0].re, tv[0].im, 4);
        wait_valid("stall");
        chk("stall_idx0", 32'(out_idx), 32'd0);
        @(negedge clk);
        chk("stall_idx1", 32'(out_idx), 32'd1);
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", s), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_idx", s),   32'(out_idx),   32'd1);
            chk($sformatf("stall%0d_re", s),    32'(out_re),    32'hE);
            chk($sformatf("stall%0d_im", s),    32'(out_im),    32'h2);
            chk($sformatf("stall%0d_bfc", s),   32'(bf_c),      32'b010);
            chk($sformatf("stall%0d_bfx", s),   bf_x, pack(tv[0].re, tv[0].im));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_idx2", 32'(out_idx), 32'd2);
        chk("stall_re2",  32'(out_re),  32'hE);
        @(negedge clk);
        chk("stall_idx3", 32'(out_idx), 32'd3);
        chk("stall_im3",  32'(out_im),  32'hE);
        @(negedge clk);
        chk("stall_drain", 32'(out_valid), 32'd0);

        // 4. reset after two samples discards the partial frame
        send_samples(tv[2].re, tv[2].im, 2);
        do_reset(2);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        send_samples(vg.re, vg.im, 4);
        collect_frame(vg, "midrst");

        // 5. back-to-back frames
        bb_re[0] = tv[0].re; bb_im[0] = tv[0].im; bb_ere[0] = tv[0].ere; bb_eim[0] = tv[0].eim;
        bb_re[1] = tv[4].re; bb_im[1] = tv[4].im; bb_ere[1] = tv[4].ere; bb_eim[1] = tv[4].eim;
        bb_re[2] = tv[5].re; bb_im[2] = tv[5].im; bb_ere[2] = tv[5].ere; bb_eim[2] = tv[5].eim;
        out_ready = 1'b1;
        fork
            begin
                fd_i = 0;
                fd_g = 0;
                while (fd_i < 12 && fd_g < 200) begin
                    in_valid = 1'b1;
                    in_re    = bb_re[fd_i/4][4*(fd_i%4) +: 4];
                    in_im    = bb_im[fd_i/4][4*(fd_i%4) +: 4];
                    fd_acc   = in_ready;
                    @(negedge clk);
                    if (fd_acc) fd_i++;
                    fd_g++;
                end
                in_valid = 1'b0;
            end
            begin
                co_n    = 0;
                co_g    = 0;
                co_gaps = 0;
                co_seen = 1'b0;
                while (co_n < 12 && co_g < 200) begin
                    if (out_valid) begin
                        co_seen = 1'b1;
                        co_j    = co_n / 4;
                        co_k    = co_n % 4;
                        chk($sformatf("b2b%0d_idx", co_n), 32'(out_idx), 32'(co_k));
                        chk($sformatf("b2b%0d_re", co_n),  32'(out_re),  32'(bb_ere[co_j][4*co_k +: 4]));
                        chk($sformatf("b2b%0d_im", co_n),  32'(out_im),  32'(bb_eim[co_j][4*co_k +: 4]));
`ifndef R4_CTRL_DBLBUF_EN
                        if (co_k != 3) chk($sformatf("b2b%0d_in_ready", co_n), 32'(in_ready), 32'd0);
`endif
                        co_n++;
                    end else if (co_seen) begin
                        co_gaps++;
                    end
                    @(negedge clk);
                    co_g++;
                end
            end
        join
        chk("b2b_count", 32'(co_n), 32'd12);
`ifdef R4_CTRL_DBLBUF_EN
        chk("b2b_gaps", 32'(co_gaps), 32'd0);
`endif

        // 6. random valid/ready, 1000 frames against the golden model
        do_reset(2);
        fork
            begin
                rf_g = 0;
                for (int fr = 0; fr < 1000; fr++) begin
                    rf_re = 16'($urandom);
                    rf_im = 16'($urandom);
                    for (int k = 0; k < 4; k++) begin
                        exp_q.push_back({2'(k), dft4(pack(rf_re, rf_im), k)});
                    end
                    for (int s = 0; s < 4; s++) begin
                        rf_acc = 1'b0;
                        while (!rf_acc && rf_g < 60000) begin
                            in_valid = 1'($urandom_range(0, 1));
                            in_re    = rf_re[4*s +: 4];
                            in_im    = rf_im[4*s +: 4];
                            rf_acc   = in_valid && in_ready;
                            @(negedge clk);
                            rf_g++;
                        end
                    end
                end
                in_valid = 1'b0;
            end
            begin
                rc_n = 0;
                rc_g = 0;
                while (rc_n < 4000 && rc_g < 60000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            n_err++;
                            $display("FAIL rand_extra: got %0h expected none", {out_idx, out_im, out_re});
                        end else begin
                            exp_v = exp_q.pop_front();
                            chk($sformatf("rand%0d", rc_n), 32'({out_idx, out_im, out_re}), 32'(exp_v));
                        end
                        rc_n++;
                    end
                    @(negedge clk);
                    rc_g++;
                end
                out_ready = 1'b1;
            end
        join
        chk("rand_count", 32'(rc_n), 32'd4000);
        chk("rand_left",  32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_r4_butter_ctrl
`default_nettype wire
